click_decoder: RTL and testbench
================================

// Module: click_decoder
// PURPOSE
//  Consumer of the single-cycle pulses produced by the button pulse generator.
//  Groups pulses arriving within a timeout window into one click event.
//  Reports single/double/.../MAX_CLICKS clicks as a one-cycle event for the UI/control FSMs.
//  Sits directly downstream of the pulse generator, in the same clock domain.
// PARAMETERS
//  WINDOW_CYCLES  8  idle cycles after the last pulse that close a sequence (>=2; 100 MHz board build overrides)
//  MAX_CLICKS     3  clicks that close a sequence immediately (>=2)
//  CNT_W          $clog2(MAX_CLICKS+1)  width of click count (derived, localparam)
// PORTS
//  clk         in   1      system clock, rising edge
//  rst         in   1      synchronous reset, active-high
//  pulso       in   1      click pulse; every cycle sampled high counts as one click
//  evt_valid   out  1      one-cycle event strobe
//  evt_clicks  out  CNT_W  click count of the event; meaningful when evt_valid=1
//  busy        out  1      sequence in progress (state != IDLE)
// BEHAVIOUR
//  - Reset: all state synchronous on clk, no async terms.
//    - Reset values: state=IDLE, count=0, timer=0, evt_valid=0, evt_clicks=0, busy=0.
//    - rst wins over every other input.
//    - rst mid-sequence discards the count; no event is emitted.
//  - Moore FSM, states IDLE, COUNT, EMIT:
//    - IDLE:  pulso=1 -> COUNT, count=1, timer=0.
//    - COUNT: pulso=1 and count+1==MAX_CLICKS -> EMIT, count=MAX_CLICKS.
//             pulso=1 otherwise -> count+1, timer=0.
//             pulso=0 and timer==WINDOW_CYCLES-1 -> EMIT.
//             pulso=0 otherwise -> timer+1.
//    - EMIT:  lasts exactly 1 cycle.
//             pulso=1 -> COUNT, count=1, timer=0 (new sequence; the click is not lost).
//             pulso=0 -> IDLE.
//  - Outputs are registered/Moore:
//    - evt_valid = (state==EMIT).
//    - evt_clicks is loaded on entry to EMIT and holds until the next EMIT.
//    - busy = (state!=IDLE).
//  - Latency:
//    - Timeout: pulse sampled at edge k, no further pulses -> evt_valid high in the cycle after edge k+WINDOW_CYCLES.
//    - Max-click: the MAX_CLICKS-th pulse sampled at edge m -> evt_valid high in the cycle after edge m.
//  - Boundaries:
//    - pulso=1 on the same edge timer==WINDOW_CYCLES-1: the pulse wins; it is counted and the timer restarts.
//    - Count never exceeds MAX_CLICKS; timer never exceeds WINDOW_CYCLES-1 (no wrap).
//    - Back-to-back pulses on consecutive cycles each count as separate clicks.
// STRUCTURE
//  - click_decoder_pkg:
//    - typedef enum logic [1:0] {IDLE, COUNT, EMIT} click_state_t.
//    - Shared with pulse generator benches.
//  - Sub-module window_timer #(WINDOW_CYCLES):
//    - Inputs: clk, rst, clr, en.
//    - Output: done = (timer==WINDOW_CYCLES-1 && en).
//    - The FSM drives clr on every accepted pulse and en while in COUNT.
//  - The FSM, count register and output registers live in click_decoder.
// TESTING  (WINDOW_CYCLES=8, MAX_CLICKS=3, 10 ns clk; drive on negedge)
//  1. rst=1 for 2 cycles, then 0 -> evt_valid=0, evt_clicks=0, busy=0 after the first edge.
//  2. One pulse at edge k -> evt_valid=1, evt_clicks=1 only in the cycle after edge k+8; busy=0 after.
//  3. Pulses at k and k+3 -> single event, evt_clicks=2, in the cycle after edge k+11.
//  4. Pulses at k, k+1, k+2 -> evt_clicks=3 in the cycle after edge k+2; no event later.
//  5. Pulse at k, second pulse exactly at k+8 (timeout edge) -> counted; event evt_clicks=2 after edge k+16.
//  6. Pulse during the EMIT cycle of test 2 -> that event stays 1; a new event evt_clicks=1 follows 8 edges later.
//  7. Pulse at k, rst=1 at k+4 -> no evt_valid ever; busy=0 after the rst edge.

Source files
------------

// File: rtl/click_decoder_pkg.sv
// click_decoder_pkg: state encoding shared by the click decoder
// and the benches of the upstream pulse generator.
package click_decoder_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        EMIT  = 2'd2
    } click_state_t;

    function automatic int cnt_width(input int max_clicks);
        return $clog2(max_clicks + 1);
    endfunction

endpackage

// File: rtl/window_timer.sv
// window_timer: idle-cycle counter that closes a click sequence
// once WINDOW_CYCLES edges pass with no new pulse.
module window_timer #(
    parameter int WINDOW_CYCLES = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic done
);

    localparam int TW = (WINDOW_CYCLES > 2) ? $clog2(WINDOW_CYCLES) : 1;
    localparam logic [TW-1:0] LAST = TW'(WINDOW_CYCLES - 1);

    logic [TW-1:0] timer;

    // restart on each pulse, count idle cycles, saturate at LAST
    always_ff @(posedge clk) begin
        if (rst) begin
            timer <= '0;
        end else if (clr) begin
            timer <= '0;
        end else if (en && (timer != LAST)) begin
            timer <= timer + TW'(1);
        end
    end

    assign done = en && (timer == LAST);

endmodule

// File: rtl/click_decoder.sv
// click_decoder: groups pulses closer than the window into one
// click event and reports its count as a one-cycle strobe.
module click_decoder
    import click_decoder_pkg::*;
#(
    parameter int WINDOW_CYCLES = 8,
    parameter int MAX_CLICKS    = 3
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 pulso,
    output logic                                 evt_valid,
    output logic [cnt_width(MAX_CLICKS)-1:0]     evt_clicks,
    output logic                                 busy
);

    localparam int CNT_W = cnt_width(MAX_CLICKS);
    localparam logic [CNT_W-1:0] MAXC = CNT_W'(MAX_CLICKS);
    localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

    click_state_t     state;
    logic [CNT_W-1:0] count;
    logic             tmr_clr;
    logic             tmr_en;
    logic             tmr_done;

    // every sampled pulse restarts the window; it only runs in COUNT
    assign tmr_clr = pulso;
    assign tmr_en  = (state == COUNT);

    window_timer #(
        .WINDOW_CYCLES(WINDOW_CYCLES)
    ) u_timer (
        .clk (clk),
        .rst (rst),
        .clr (tmr_clr),
        .en  (tmr_en),
        .done(tmr_done)
    );

    // sequence FSM with registered Moore outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            count      <= '0;
            evt_valid  <= 1'b0;
            evt_clicks <= '0;
            busy       <= 1'b0;
        end else begin
            evt_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (pulso) begin
                        state <= COUNT;
                        count <= ONE;
                        busy  <= 1'b1;
                    end
                end
                COUNT: begin
                    if (pulso) begin
                        if ((count + ONE) == MAXC) begin
                            state      <= EMIT;
                            count      <= MAXC;
                            evt_valid  <= 1'b1;
                            evt_clicks <= MAXC;
                        end else begin
                            count <= count + ONE;
                        end
                    end else if (tmr_done) begin
                        state      <= EMIT;
                        evt_valid  <= 1'b1;
                        evt_clicks <= count;
                    end
                end
                EMIT: begin
                    if (pulso) begin
                        state <= COUNT;
                        count <= ONE;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_click_decoder.sv
// tb_click_decoder: directed and random pulse trains checked against
// a gap-based reference model through an event scoreboard.
module tb_click_decoder;

    localparam int W  = 8;
    localparam int M  = 3;
    localparam int CW = 2;
    localparam int N  = 2400;

    logic          clk = 1'b0;
    logic          rst;
    logic          pulso;
    logic          evt_valid;
    logic [CW-1:0] evt_clicks;
    logic          busy;

    typedef struct {
        int ev;
        int n;
    } evt_t;

    bit   pv [N+1];
    bit   rv [N+1];
    bit   bx [N+1];
    evt_t exq[$];

    int errors = 0;
    int checks = 0;
    int edge_n = 0;
    int held   = 0;

    click_decoder #(
        .WINDOW_CYCLES(W),
        .MAX_CLICKS   (M)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .pulso     (pulso),
        .evt_valid (evt_valid),
        .evt_clicks(evt_clicks),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_n++;

    task automatic close_seq(input int s, input int ev, input int n);
        evt_t t;
        t.ev = ev;
        t.n  = n;
        exq.push_back(t);
        for (int i = s; i <= ev; i++) bx[i] = 1'b1;
    endtask

    // A pulse joins the open sequence if it comes no more than W edges
    // after the previous one; the event fires W edges after the last
    // pulse, or on the pulse that reaches M clicks.
    task automatic run_model();
        bit open = 1'b0;
        int cnt  = 0;
        int last = 0;
        int st   = 0;
        for (int e = 1; e <= N; e++) begin
            if (open && e > last + W) begin
                close_seq(st, last + W, cnt);
                open = 1'b0;
            end
            if (rv[e]) begin
                if (open) for (int i = st; i < e; i++) bx[i] = 1'b1;
                open = 1'b0;
            end else if (pv[e]) begin
                if (open) begin
                    cnt++;
                    last = e;
                    if (cnt == M) begin
                        close_seq(st, e, cnt);
                        open = 1'b0;
                    end
                end else begin
                    open = 1'b1;
                    cnt  = 1;
                    st   = e;
                    last = e;
                end
            end
        end
        if (open) close_seq(st, last + W, cnt);
    endtask

    task automatic build_stim();
        int dens;
        for (int e = 0; e <= N; e++) begin
            pv[e] = 1'b0;
            rv[e] = 1'b0;
            bx[e] = 1'b0;
        end
        rv[1] = 1'b1;
        rv[2] = 1'b1;
        pv[10] = 1'b1;
        pv[19] = 1'b1;
        pv[40] = 1'b1;
        pv[43] = 1'b1;
        pv[70] = 1'b1;
        pv[71] = 1'b1;
        pv[72] = 1'b1;
        pv[100] = 1'b1;
        pv[108] = 1'b1;
        pv[130] = 1'b1;
        rv[134] = 1'b1;
        dens = 10;
        for (int e = 150; e <= N - W - 10; e++) begin
            if ((e % 50) == 0) begin
                case ($urandom_range(0, 2))
                    0:       dens = 5;
                    1:       dens = 15;
                    default: dens = 45;
                endcase
            end
            rv[e] = ($urandom_range(0, 249) == 0);
            pv[e] = ($urandom_range(0, 99) < dens);
        end
    endtask

    // monitor: per-cycle busy/held-count checks and event scoreboard
    always @(negedge clk) begin
        evt_t t;
        if (edge_n > 0 && edge_n <= N) begin
            if (rv[edge_n]) held = 0;
            while (exq.size() > 0 && exq[0].ev < edge_n) begin
                t = exq.pop_front();
                checks++;
                errors++;
                $display("FAIL missed_event: expected clicks=%0d at edge %0d, got no event",
                         t.n, t.ev);
            end
            checks++;
            if (busy !== bx[edge_n]) begin
                errors++;
                $display("FAIL busy edge %0d: got %b expected %b",
                         edge_n, busy, bx[edge_n]);
            end
            if (evt_valid !== 1'b0) begin
                checks++;
                if (exq.size() == 0 || exq[0].ev != edge_n) begin
                    errors++;
                    $display("FAIL spurious_event edge %0d: got valid=%b clicks=%0d, expected none",
                             edge_n, evt_valid, evt_clicks);
                end else begin
                    t = exq.pop_front();
                    held = t.n;
                    if (evt_valid !== 1'b1 || evt_clicks !== CW'(t.n)) begin
                        errors++;
                        $display("FAIL event edge %0d: got clicks=%0d expected %0d",
                                 edge_n, evt_clicks, t.n);
                    end
                end
            end
            checks++;
            if (evt_clicks !== CW'(held)) begin
                errors++;
                $display("FAIL evt_clicks_hold edge %0d: got %0d expected %0d",
                         edge_n, evt_clicks, held);
            end
        end
    end

    initial begin
        build_stim();
        run_model();
        rst   = rv[1];
        pulso = pv[1];
        for (int e = 2; e <= N; e++) begin
            @(negedge clk);
            rst   = rv[e];
            pulso = pv[e];
        end
        @(negedge clk);
        #1;
        checks++;
        if (exq.size() != 0) begin
            errors++;
            $display("FAIL pending_events: got %0d left expected 0", exq.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
